// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one owner at a time, registered one-hot grant, rotating priority.
// Define ARB_TIMEOUT_EN to add a watchdog that revokes a grant held for MAX_HOLD cycles.
module rr_arbiter #(
   parameter int unsigned REQ_CNT  = 4,
   parameter int unsigned MAX_HOLD = 16,
   localparam int unsigned IDX_W   = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
   input  logic               clk_i,
   input  logic               srst_i,
   input  logic [REQ_CNT-1:0] req_i,
   input  logic               done_i,
   output logic [REQ_CNT-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_val_o,
   output logic               timeout_o
);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [REQ_CNT-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               val_q, val_d;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               to_q, to_d;
`endif

   logic [REQ_CNT-1:0] req_rot;
   logic               win_found;
   int unsigned        win_off;
   int unsigned        win_sum;
   logic [IDX_W-1:0]   win_idx;
   logic [REQ_CNT-1:0] win_oh;
   logic               owner_req;
   logic               release_req;
   logic [IDX_W-1:0]   ptr_nxt;

   // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
   always_comb begin
      req_rot   = REQ_CNT'({req_i, req_i} >> ptr_q);
      win_found = 1'b0;
      win_off   = 0;
      for (int unsigned i = 0; i < REQ_CNT; i++) begin
         if (!win_found && req_rot[i]) begin
            win_found = 1'b1;
            win_off   = i;
         end
      end
      win_sum = int'(ptr_q) + win_off;
      if (win_sum >= REQ_CNT) begin
         win_sum = win_sum - REQ_CNT;
      end
      win_idx = IDX_W'(win_sum);
      win_oh  = win_found ? (REQ_CNT'(1) << win_idx) : '0;
   end

   always_comb begin
      owner_req   = |(gnt_q & req_i);
      release_req = done_i | ~owner_req;
      ptr_nxt     = (idx_q == IDX_W'(REQ_CNT - 1)) ? '0 : idx_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      val_d   = val_q;
`ifdef ARB_TIMEOUT_EN
      hold_d  = hold_q;
      to_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               gnt_d   = win_oh;
               idx_d   = win_idx;
               val_d   = 1'b1;
               state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
               hold_d  = '0;
`endif
            end
         end
         ST_BUSY: begin
            // A normal release outranks an expiring watchdog in the same cycle.
            if (release_req) begin
               gnt_d   = '0;
               idx_d   = '0;
               val_d   = 1'b0;
               state_d = ST_IDLE;
               ptr_d   = ptr_nxt;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               gnt_d   = '0;
               idx_d   = '0;
               val_d   = 1'b0;
               state_d = ST_IDLE;
               ptr_d   = ptr_nxt;
               to_d    = 1'b1;
            end else begin
               hold_d  = hold_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            val_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         val_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_q  <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
`ifdef ARB_TIMEOUT_EN
         hold_q  <= hold_d;
         to_q    <= to_d;
`endif
      end
   end

   assign gnt_o     = gnt_q;
   assign gnt_idx_o = idx_q;
   assign gnt_val_o = val_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout_o = to_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule
